// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream handshake and instruction-memory write bus used
//                by the program loader. The slave modport is the loader's
//                view; the master modport is the stream source / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Length-prefixed byte-stream loader for instruction memory.
//                Packs bytes little-endian into 32-bit words written to
//                sequential word addresses from 0, and holds the core in reset
//                until a complete image is in memory.
//                Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a
//                trailing XOR checksum byte over the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  wire                 clk,
  input  wire                 reset,
  input  wire                 reload,
  imem_loader_if.slave        bus,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Largest legal word count, widened so the 16-bit length compares cleanly.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_PAYLOAD = S_CSUM;
`else
  localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [23:0]           data_q, data_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  in_ready_q, in_ready_d;
  logic                  core_reset_q, core_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_new;
  logic        last_word;

  // in_ready is a flop, so a transfer never depends combinationally on in_valid.
  assign accept    = bus.in_valid && in_ready_q;
  assign len_new   = {bus.in_data, len_lo_q};
  assign last_word = (17'(word_cnt_q) + 17'd1) == 17'(len_q);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    data_d      = data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_lo_d = bus.in_data;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (accept) begin
          len_d      = len_new;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
          if (17'(len_new) > CAPACITY) begin
            state_d = S_ERR;
          end else if (len_new == 16'd0) begin
            state_d = S_AFTER_PAYLOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: data_d[7:0]   = bus.in_data;
            2'd1: data_d[15:8]  = bus.in_data;
            2'd2: data_d[23:16] = bus.in_data;
            default: begin
              // Fourth byte completes the word: write it and advance.
              mem_we_d    = 1'b1;
              mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
              mem_wdata_d = {bus.in_data, data_q};
              word_cnt_d  = word_cnt_q + (ADDR_WIDTH+1)'(1);
              if (last_word) begin
                state_d = S_AFTER_PAYLOAD;
              end
            end
          endcase
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif

      S_DONE, S_ERR: begin
        if (reload) begin
          state_d    = S_LEN0;
          byte_cnt_d = 2'd0;
          word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      default: begin
        state_d = S_LEN0;
      end
    endcase

    // Status outputs are registered copies of the upcoming state.
    in_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CSUM);
    core_reset_d = (state_d != S_DONE);
    load_done_d  = (state_d == S_DONE);
    load_error_d = (state_d == S_ERR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN0;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= '0;
      len_lo_q     <= 8'd0;
      len_q        <= 16'd0;
      data_q       <= 24'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      in_ready_q   <= 1'b1;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      data_q       <= data_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      in_ready_q   <= in_ready_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_reset    = core_reset_q;
  assign load_done     = load_done_q;
  assign load_error    = load_error_q;
  assign words_loaded  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Follows the
//                IMEM_LOADER_CHECKSUM_EN setting of the design build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_WIDTH = 8;

  logic                clk;
  logic                reset;
  logic                reload;
  logic                core_reset;
  logic                load_done;
  logic                load_error;
  logic [ADDR_WIDTH:0] words_loaded;

  imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  imem_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .bus          (bus.slave),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log captured on the falling edge.
  logic [ADDR_WIDTH-1:0] wr_addr [0:1023];
  logic [31:0]           wr_data [0:1023];
  int                    wr_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = bus.mem_addr;
      wr_data[wr_cnt] = bus.mem_wdata;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  logic [7:0]  stream [0:9];
  logic [7:0]  csum;
  logic [7:0]  b;
  logic [31:0] last_word;
  int          base;

  initial begin
    stream[0] = 8'h02; stream[1] = 8'h00;
    stream[2] = 8'h78; stream[3] = 8'h56; stream[4] = 8'h34; stream[5] = 8'h12;
    stream[6] = 8'hEF; stream[7] = 8'hBE; stream[8] = 8'hAD; stream[9] = 8'hDE;

    reset        = 1'b1;
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // ---- reset state
    step();
    reset = 1'b0;
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_load_error", 64'(load_error), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);

    // ---- N=2 at full rate
    base = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      send_byte(stream[i]);
      if (i == 4) chk("full_no_early_we", 64'(bus.mem_we), 64'd0);
    end
    chk("full_w0_we", 64'(bus.mem_we), 64'd1);
    chk("full_w0_addr", 64'(bus.mem_addr), 64'd0);
    chk("full_w0_data", 64'(bus.mem_wdata), 64'h12345678);
    chk("full_w0_words", 64'(words_loaded), 64'd1);
    chk("full_w0_core_reset", 64'(core_reset), 64'd1);
    for (int i = 6; i < 10; i++) send_byte(stream[i]);
    chk("full_w1_we", 64'(bus.mem_we), 64'd1);
    chk("full_w1_addr", 64'(bus.mem_addr), 64'd1);
    chk("full_w1_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
    chk("full_w1_words", 64'(words_loaded), 64'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("full_wait_csum_done", 64'(load_done), 64'd0);
    send_byte(8'h2A);
`endif
    chk("full_done", 64'(load_done), 64'd1);
    chk("full_core_released", 64'(core_reset), 64'd0);
    chk("full_in_ready_low", 64'(bus.in_ready), 64'd0);
    // Bytes offered after completion must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step(); step(); step();
    bus.in_valid = 1'b0;
    chk("full_wr_count", 64'(wr_cnt - base), 64'd2);
    chk("full_still_done", 64'(load_done), 64'd1);
    chk("full_words_hold", 64'(words_loaded), 64'd2);

    // ---- reload
    do_reload();
    chk("reload_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reload_done_clr", 64'(load_done), 64'd0);
    chk("reload_core_reset", 64'(core_reset), 64'd1);
    chk("reload_words_clr", 64'(words_loaded), 64'd0);

    // ---- same stream with in_valid toggling
    base = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i]);
      step();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A);
    step();
`endif
    chk("tog_wr_count", 64'(wr_cnt - base), 64'd2);
    chk("tog_w0_addr", 64'(wr_addr[base]), 64'd0);
    chk("tog_w0_data", 64'(wr_data[base]), 64'h12345678);
    chk("tog_w1_addr", 64'(wr_addr[base+1]), 64'd1);
    chk("tog_w1_data", 64'(wr_data[base+1]), 64'hDEADBEEF);
    chk("tog_done", 64'(load_done), 64'd1);
    chk("tog_in_ready_low", 64'(bus.in_ready), 64'd0);

    // ---- oversize length N=257
    do_reload();
    base = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h01);
    chk("big_error", 64'(load_error), 64'd1);
    chk("big_no_we", 64'(bus.mem_we), 64'd0);
    chk("big_core_reset", 64'(core_reset), 64'd1);
    chk("big_in_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    chk("big_no_writes", 64'(wr_cnt - base), 64'd0);
    do_reload();
    chk("big_reload_ready", 64'(bus.in_ready), 64'd1);
    chk("big_reload_err_clr", 64'(load_error), 64'd0);

    // ---- N=1, payload 01 02 03 04
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("n1_data", 64'(bus.mem_wdata), 64'h04030201);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h05);
    chk("bad_csum_error", 64'(load_error), 64'd1);
    chk("bad_csum_core_reset", 64'(core_reset), 64'd1);
    chk("bad_csum_words", 64'(words_loaded), 64'd1);
    do_reload();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
`endif
    chk("n1_done", 64'(load_done), 64'd1);
    chk("n1_no_error", 64'(load_error), 64'd0);

    // ---- N=0
    do_reload();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n0_wait_csum", 64'(load_done), 64'd0);
    send_byte(8'h00);
`endif
    chk("n0_done", 64'(load_done), 64'd1);
    chk("n0_words", 64'(words_loaded), 64'd0);

    // ---- N=256, full capacity
    do_reload();
    base = wr_cnt;
    csum = 8'h00;
    last_word = 32'd0;
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(i * 7 + k * 3 + 1);
        csum = csum ^ b;
        last_word[k*8 +: 8] = b;
        send_byte(b);
      end
    end
    chk("cap_last_addr", 64'(bus.mem_addr), 64'd255);
    chk("cap_last_data", 64'(bus.mem_wdata), 64'(last_word));
    chk("cap_words", 64'(words_loaded), 64'd256);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    chk("cap_done", 64'(load_done), 64'd1);
    step();
    chk("cap_wr_count", 64'(wr_cnt - base), 64'd256);

    // ---- reset mid-load after 6 bytes, then fresh N=1 load
    do_reload();
    base = wr_cnt;
    for (int i = 0; i < 6; i++) send_byte(stream[i]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_no_we", 64'(bus.mem_we), 64'd0);
    chk("mid_rst_words", 64'(words_loaded), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_core_reset", 64'(core_reset), 64'd1);
    chk("mid_rst_one_write", 64'(wr_cnt - base), 64'd1);
    chk("mid_rst_w0_addr", 64'(wr_addr[base]), 64'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk("fresh_addr", 64'(bus.mem_addr), 64'd0);
    chk("fresh_data", 64'(bus.mem_wdata), 64'hDDCCBBAA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("fresh_done", 64'(load_done), 64'd1);
    chk("fresh_core_released", 64'(core_reset), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
